mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder that sits behind the IF/MEM arbiter and serves its registered request bus (address, write data, read/write strobes, grant tags).
- Holds a DEPTH x DATA_W unified instruction/data array.
- Inserts programmable wait states, then returns read data, or a write acknowledge, to whichever requester the grant tag names.
- Asserts busy so the arbiter holds its request until the responder can take it.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- DEPTH, 256, number of array words; must equal 2**ADDR_W.
- WAIT_STATES, 1, extra access cycles before the response; legal range 0..7.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_addr  in  ADDR_W  request address.
- mem_wdata  in  DATA_W  write data.
- mem_read  in  1  read strobe.
- mem_write  in  1  write strobe.
- granted_to_if  in  1  request belongs to IF.
- granted_to_mem  in  1  request belongs to MEM.
- busy  out  1  responder is occupied; new requests are ignored.
- if_rdata  out  DATA_W  read data returned to IF.
- if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
- mem_rdata  out  DATA_W  read data returned to MEM.
- mem_rvalid  out  1  one-cycle pulse: mem_rdata is valid.
- wr_ack  out  1  one-cycle pulse: write has been committed.
- par_err  out  1  parity error flag (see Optional Feature).

Behaviour:
- Reset is sampled only on the clk edge while reset==0.
  - FSM goes to IDLE and the wait counter clears.
  - busy, if_rvalid, mem_rvalid, wr_ack, par_err go to 0.
  - if_rdata and mem_rdata go to 0.
  - Array contents are NOT cleared.
- States: IDLE, ACCESS, RESP.
- IDLE: a request is accepted on an edge where (mem_read|mem_write) is high and at least one grant tag is high.
  - On acceptance, latch addr, wdata, op and tag; busy goes to 1.
  - Next state is ACCESS if WAIT_STATES>0, otherwise RESP.
  - A request with no grant tag set is ignored; state stays IDLE.
- Tag resolution: granted_to_mem takes priority; IF is the target only when granted_to_if=1 and granted_to_mem=0.
- Op resolution: if mem_write and mem_read are both high, the request is a write; no read data is returned.
- ACCESS: a down-counter is loaded with WAIT_STATES-1 and decrements each cycle; at 0 the FSM moves to RESP. ACCESS therefore lasts exactly WAIT_STATES cycles.
- RESP lasts exactly one cycle, then the FSM returns to IDLE and busy returns to 0.
  - Write: array[addr] is updated at the edge that enters RESP; wr_ack=1 during RESP.
  - Read: the array is read at the edge that enters RESP. The tagged rdata register is loaded and its rvalid is 1 during RESP. The other requester's rdata/rvalid are unchanged (rvalid stays 0).
- Latency: for a request accepted at edge E, the response pulse is high in the cycle after edge E+WAIT_STATES.
- Throughput: one access per WAIT_STATES+2 cycles. No request is accepted in ACCESS or RESP; inputs are not sampled then, so the arbiter must hold or re-issue.
- Output hold: if_rdata and mem_rdata hold their last value until the next read for the same tag.
- Read-after-write to the same address returns the new data. There is no forwarding need, because accesses are serialized.
- Address wrap: the address is used modulo DEPTH. Address 0xFF is valid; there is no out-of-range error.
- Reset during ACCESS or RESP aborts the access.
  - A pending write not yet committed is dropped.
  - A write already committed stays committed.
  - No response pulse is produced.

Optional Feature:
- Macro: MEM_PARITY_EN.
- With MEM_PARITY_EN defined:
  - Each array word stores an extra even-parity bit, computed from the write data.
  - On a read, recomputed parity is compared with the stored bit.
  - On mismatch, par_err=1 for the RESP cycle, coincident with rvalid; data is still returned unmodified.
  - par_err is never set on writes.
- Without MEM_PARITY_EN: no parity storage; par_err is tied to 0.

Test Plan:
- WAIT_STATES=1. Write 0x3C to address 0x10 with the MEM tag, accepted at edge E -> wr_ack=1 only in the cycle after E+1; busy=1 from E to the end of RESP; if_rvalid=0 and mem_rvalid=0 throughout.
- Then read 0x10 with the IF tag -> if_rvalid pulses once with if_rdata=0x3C; mem_rvalid stays 0 and mem_rdata is unchanged.
- A second request is presented during busy and held for one cycle only -> it is ignored, with no second response. The same request held until busy falls -> it is accepted on the first IDLE edge.
- Both grant tags set with mem_read high at address 0xFF, which holds 0xA5 -> mem_rvalid pulses with mem_rdata=0xA5; if_rvalid stays 0. Then mem_read and mem_write both high with wdata 0x11 -> treated as a write: wr_ack pulses and array[0xFF]=0x11.
- A write of 0x77 to 0x20 is accepted, then reset=0 is asserted during ACCESS -> outputs are 0, the FSM is IDLE, there is no wr_ack, and a later read of 0x20 returns the old value.
- With MEM_PARITY_EN defined, the bench backdoor-flips the stored parity bit of address 0x05 and then reads it -> par_err=1 coincident with rvalid. Without the macro, the same sequence gives par_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder behind the IF/MEM arbiter.
// Serves one request at a time from a unified DEPTH x DATA_W array.
// It inserts WAIT_STATES access cycles and then returns a one-cycle
// response pulse to the requester named by the grant tag.
// Optional build macro: MEM_PARITY_EN stores an even-parity bit per word
// and flags par_err on a read whose stored parity does not match the data.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              granted_to_if,
    input  logic              granted_to_mem,
    output logic              busy,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    output logic              wr_ack,
    output logic              par_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    localparam logic [2:0] WS_LOAD = NO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);

    logic [1:0]        state;
    logic [2:0]        wait_cnt;

    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_write;
    logic              lat_to_mem;

    logic [DATA_W-1:0] mem_array [DEPTH];

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_write;
    logic              acc_to_mem;
    logic [DATA_W-1:0] rd_word;

`ifdef MEM_PARITY_EN
    logic              par_array [DEPTH];
`endif

    // Select the live request in IDLE (needed when WAIT_STATES==0 commits on
    // the accepting edge) and the latched request otherwise.
    always_comb begin
        accept     = (state == IDLE) && (mem_read || mem_write) &&
                     (granted_to_if || granted_to_mem);
        acc_addr   = lat_addr;
        acc_wdata  = lat_wdata;
        acc_write  = lat_write;
        acc_to_mem = lat_to_mem;
        if (state == IDLE) begin
            acc_addr   = mem_addr;
            acc_wdata  = mem_wdata;
            acc_write  = mem_write;
            acc_to_mem = granted_to_mem;
        end
        commit  = ((state == ACCESS) && (wait_cnt == 3'd0)) || (accept && NO_WAIT);
        rd_word = mem_array[acc_addr];
    end

    assign busy = (state != IDLE);

    // Control FSM: IDLE -> (ACCESS x WAIT_STATES) -> RESP -> IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state    <= ACCESS;
                            wait_cnt <= WS_LOAD;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 3'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the accepted request; write beats read, MEM tag beats IF tag.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr   <= mem_addr;
            lat_wdata  <= mem_wdata;
            lat_write  <= mem_write;
            lat_to_mem <= granted_to_mem;
        end
    end

    // Array update on the edge entering RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (reset && commit && acc_write) begin
            mem_array[acc_addr] <= acc_wdata;
`ifdef MEM_PARITY_EN
            par_array[acc_addr] <= ^acc_wdata;
`endif
        end
    end

    // Response registers: one-cycle pulses during RESP, rdata held per tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_rvalid  <= 1'b0;
            mem_rvalid <= 1'b0;
            wr_ack     <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_rvalid  <= 1'b0;
            mem_rvalid <= 1'b0;
            wr_ack     <= 1'b0;
            if (commit) begin
                if (acc_write) begin
                    wr_ack <= 1'b1;
                end else if (acc_to_mem) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= rd_word;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= rd_word;
                end
            end
        end
    end

`ifdef MEM_PARITY_EN
    // Parity check on reads, flagged alongside the rvalid pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_err <= 1'b0;
        end else begin
            par_err <= commit && !acc_write && ((^rd_word) != par_array[acc_addr]);
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule
